// File: rtl/bldc_motor_supervisor_if.sv
// Command/status bundle between the SPI register block (master) and the
// per-motor supervisor (slave).
interface bldc_motor_supervisor_if #(
    parameter int unsigned DUTY_CYCLE_WIDTH = 10
);
    logic [DUTY_CYCLE_WIDTH-1:0] cmd_duty;
    logic                        cmd_valid;
    logic                        clear_fault;
    logic                        connected;
    logic                        en_out;
    logic [DUTY_CYCLE_WIDTH-1:0] duty_out;
    logic                        busy;
    logic                        fault_latched;
    logic [2:0]                  state;

    modport master (
        output cmd_duty, cmd_valid, clear_fault, connected,
        input  en_out, duty_out, busy, fault_latched, state
    );

    modport slave (
        input  cmd_duty, cmd_valid, clear_fault, connected,
        output en_out, duty_out, busy, fault_latched, state
    );
endinterface

// File: rtl/bldc_motor_supervisor.sv
// Per-motor sequencer: slew-limited signed-magnitude duty, connection watchdog
// with grace window, cooldown/retry and fault lockout.
`ifndef LOG2
`define LOG2(x) ($clog2(x))
`endif

module bldc_motor_supervisor #(
    parameter int unsigned DUTY_CYCLE_WIDTH = 10,
    parameter int unsigned RAMP_DIV         = 256,
    parameter int unsigned RAMP_STEP        = 4,
    parameter int unsigned GRACE_CYCLES     = 4096,
    parameter int unsigned COOLDOWN_CYCLES  = 18432,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    bldc_motor_supervisor_if.slave  bus
);
    localparam int unsigned W        = DUTY_CYCLE_WIDTH;
    localparam int unsigned MAG_W    = W - 1;
    localparam int unsigned MAG_MAX  = (2 ** MAG_W) - 1;
    localparam int unsigned STEP_SAT = (RAMP_STEP > MAG_MAX) ? MAG_MAX : RAMP_STEP;
    localparam int unsigned PRESC_W  = `LOG2(RAMP_DIV + 1);
    localparam int unsigned GRACE_W  = `LOG2(GRACE_CYCLES + 1);
    localparam int unsigned COOL_W   = `LOG2(COOLDOWN_CYCLES + 1);
    localparam int unsigned RETRY_W  = `LOG2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAMP     = 3'd1,
        RUN      = 3'd2,
        COOLDOWN = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    state_t             state_q, state_n;
    logic               en_q, en_n;
    logic               dir_q, dir_n;
    logic [MAG_W-1:0]   mag_q, mag_n;
    logic [W-1:0]       target_q, target_n;
    logic [RETRY_W-1:0] retry_q, retry_n;
    logic [PRESC_W-1:0] presc_q, presc_n;
    logic [GRACE_W-1:0] grace_q;
    logic [COOL_W-1:0]  cool_q, cool_n;
    logic               busy_q, fault_q;

    logic               tdir;
    logic [MAG_W-1:0]   tmag;
    logic [MAG_W-1:0]   diff;
    logic [MAG_W-1:0]   stp;
    logic               tick;
    logic               fault;

    assign tdir  = target_q[W-1];
    assign tmag  = target_q[MAG_W-1:0];
    assign tick  = (presc_q == PRESC_W'(RAMP_DIV - 1));
    assign fault = en_q && (grace_q == GRACE_W'(GRACE_CYCLES)) && !bus.connected &&
                   ((state_q == RAMP) || (state_q == RUN));

    // Distance to travel this tick, clamped to the step size so there is no overshoot.
    always_comb begin
        diff = '0;
        if (dir_q != tdir)      diff = mag_q;
        else if (mag_q < tmag)  diff = tmag - mag_q;
        else                    diff = mag_q - tmag;
        stp = (diff < MAG_W'(STEP_SAT)) ? diff : MAG_W'(STEP_SAT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            dir_q    <= 1'b0;
            mag_q    <= '0;
            target_q <= '0;
            retry_q  <= '0;
            presc_q  <= '0;
            grace_q  <= '0;
            cool_q   <= '0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            en_q     <= en_n;
            dir_q    <= dir_n;
            mag_q    <= mag_n;
            target_q <= target_n;
            retry_q  <= retry_n;
            presc_q  <= presc_n;
            cool_q   <= cool_n;
            busy_q   <= (state_n == RAMP) || (state_n == COOLDOWN);
            fault_q  <= (state_n == LOCKOUT);
            // Grace window restarts on every enable rising edge, then saturates.
            if (en_n && !en_q)
                grace_q <= '0;
            else if (en_q && (grace_q != GRACE_W'(GRACE_CYCLES)))
                grace_q <= grace_q + GRACE_W'(1);
        end
    end

    always_comb begin
        state_n  = state_q;
        en_n     = en_q;
        dir_n    = dir_q;
        mag_n    = mag_q;
        target_n = target_q;
        retry_n  = retry_q;
        presc_n  = '0;
        cool_n   = '0;

        if (bus.cmd_valid && !fault && (state_q != LOCKOUT))
            target_n = bus.cmd_duty;

        case (state_q)
            IDLE: begin
                en_n  = 1'b0;
                dir_n = 1'b0;
                mag_n = '0;
                if (tmag != '0) begin
                    state_n = RAMP;
                    en_n    = 1'b1;
                    dir_n   = tdir;
                end
            end
            RAMP: begin
                if ((mag_q == '0) && (tmag == '0)) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    dir_n   = 1'b0;
                    retry_n = '0;
                end else if (({dir_q, mag_q} == target_q) && (mag_q != '0)) begin
                    state_n = RUN;
                end else begin
                    presc_n = tick ? '0 : presc_q + PRESC_W'(1);
                    if (tick) begin
                        if (dir_q != tdir) begin
                            // Fold toward zero first; direction flips once magnitude hits 0.
                            mag_n = mag_q - stp;
                            if (mag_n == '0) dir_n = tdir;
                        end else if (mag_q < tmag) begin
                            mag_n = mag_q + stp;
                        end else begin
                            mag_n = mag_q - stp;
                        end
                    end
                end
            end
            RUN: begin
                if ({dir_q, mag_q} != target_q) state_n = RAMP;
            end
            COOLDOWN: begin
                en_n  = 1'b0;
                dir_n = 1'b0;
                mag_n = '0;
                if (cool_q == COOL_W'(COOLDOWN_CYCLES - 1)) begin
                    if (tmag != '0) begin
                        state_n = RAMP;
                        en_n    = 1'b1;
                        dir_n   = tdir;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cool_n = cool_q + COOL_W'(1);
                end
            end
            LOCKOUT: begin
                en_n     = 1'b0;
                dir_n    = 1'b0;
                mag_n    = '0;
                target_n = '0;
                if (bus.clear_fault) begin
                    state_n = IDLE;
                    retry_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
                dir_n   = 1'b0;
                mag_n   = '0;
            end
        endcase

        // Connection loss overrides whatever the state wanted this cycle.
        if (fault) begin
            en_n    = 1'b0;
            dir_n   = 1'b0;
            mag_n   = '0;
            presc_n = '0;
            cool_n  = '0;
            retry_n = retry_q + RETRY_W'(1);
            if (retry_n == RETRY_W'(MAX_RETRIES)) begin
                state_n  = LOCKOUT;
                target_n = '0;
            end else begin
                state_n = COOLDOWN;
            end
        end
    end

    assign bus.en_out        = en_q;
    assign bus.duty_out      = {dir_q, mag_q};
    assign bus.busy          = busy_q;
    assign bus.fault_latched = fault_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_bldc_motor_supervisor.sv
// Directed bench for bldc_motor_supervisor with small ramp/grace/cooldown values.
module tb_bldc_motor_supervisor;
    localparam int unsigned W = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    bldc_motor_supervisor_if #(.DUTY_CYCLE_WIDTH(W)) bus ();

    bldc_motor_supervisor #(
        .DUTY_CYCLE_WIDTH(W),
        .RAMP_DIV        (4),
        .RAMP_STEP       (8),
        .GRACE_CYCLES    (8),
        .COOLDOWN_CYCLES (16),
        .MAX_RETRIES     (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n active edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [W-1:0] v);
        bus.cmd_duty  = v;
        bus.cmd_valid = 1'b1;
        step(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic en,
                              input logic [W-1:0] duty);
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".en"},    32'(bus.en_out), 32'(en));
        check({tag, ".duty"},  32'(bus.duty_out), 32'(duty));
    endtask

    initial begin
        reset           = 1'b1;
        bus.cmd_duty    = '0;
        bus.cmd_valid   = 1'b0;
        bus.clear_fault = 1'b0;
        bus.connected   = 1'b1;
        step(2);
        reset = 1'b0;
        check_outs("rst", 3'd0, 1'b0, 10'h000);
        check("rst.busy",  32'(bus.busy), 32'd0);
        check("rst.fault", 32'(bus.fault_latched), 32'd0);
        step(3);
        check_outs("idle", 3'd0, 1'b0, 10'h000);

        // Ramp up to 0x014 in steps of 8 every 4 clocks
        send_cmd(10'h014);
        step(1);
        check_outs("up.entry", 3'd1, 1'b1, 10'h000);
        check("up.busy", 32'(bus.busy), 32'd1);
        step(3);
        check("up.r3", 32'(bus.duty_out), 32'h000);
        step(1);
        check("up.r4", 32'(bus.duty_out), 32'h008);
        step(4);
        check("up.r8", 32'(bus.duty_out), 32'h010);
        step(4);
        check_outs("up.r12", 3'd1, 1'b1, 10'h014);
        step(1);
        check_outs("up.run", 3'd2, 1'b1, 10'h014);
        check("up.busy0", 32'(bus.busy), 32'd0);

        // Reversal through zero to 0x20C
        send_cmd(10'h20C);
        check("rev.hold", 32'(bus.state), 32'd2);
        step(1);
        check("rev.ramp", 32'(bus.state), 32'd1);
        step(4);
        check("rev.d1", 32'(bus.duty_out), 32'h00C);
        step(4);
        check("rev.d2", 32'(bus.duty_out), 32'h004);
        step(4);
        check("rev.d3", 32'(bus.duty_out), 32'h200);
        step(4);
        check("rev.d4", 32'(bus.duty_out), 32'h208);
        step(4);
        check("rev.d5", 32'(bus.duty_out), 32'h20C);
        step(1);
        check_outs("rev.run", 3'd2, 1'b1, 10'h20C);

        // Reset while running
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_outs("mid.rst", 3'd0, 1'b0, 10'h000);
        check("mid.busy",  32'(bus.busy), 32'd0);
        check("mid.fault", 32'(bus.fault_latched), 32'd0);
        step(3);
        check("mid.tgt0", 32'(bus.state), 32'd0);

        // Connection loss inside grace is ignored; after grace it faults
        send_cmd(10'h014);
        step(1);
        step(3);
        bus.connected = 1'b0;
        step(1);
        bus.connected = 1'b1;
        check_outs("grace", 3'd1, 1'b1, 10'h008);
        step(5);
        bus.connected = 1'b0;
        step(1);
        bus.connected = 1'b1;
        check_outs("f1", 3'd3, 1'b0, 10'h000);
        check("f1.busy", 32'(bus.busy), 32'd1);
        step(15);
        check("cool.15", 32'(bus.state), 32'd3);
        step(1);
        check_outs("cool.exit", 3'd1, 1'b1, 10'h000);

        // Second fault exhausts retries
        bus.connected = 1'b0;
        step(8);
        check_outs("f2.pre", 3'd1, 1'b1, 10'h010);
        step(1);
        bus.connected = 1'b1;
        check_outs("lock", 3'd4, 1'b0, 10'h000);
        check("lock.flt",  32'(bus.fault_latched), 32'd1);
        check("lock.busy", 32'(bus.busy), 32'd0);
        send_cmd(10'h050);
        step(2);
        check_outs("lock.cmd", 3'd4, 1'b0, 10'h000);
        bus.clear_fault = 1'b1;
        step(1);
        bus.clear_fault = 1'b0;
        check("clr.state", 32'(bus.state), 32'd0);
        check("clr.flt",   32'(bus.fault_latched), 32'd0);
        step(3);
        check_outs("clr.tgt0", 3'd0, 1'b0, 10'h000);

        // One fault, then commanded stop clears the retry count
        send_cmd(10'h014);
        step(10);
        bus.connected = 1'b0;
        step(1);
        bus.connected = 1'b1;
        check("r.f1", 32'(bus.state), 32'd3);
        step(16);
        check("r.ramp", 32'(bus.state), 32'd1);
        step(8);
        check("r.d10", 32'(bus.duty_out), 32'h010);
        send_cmd(10'h000);
        step(3);
        check("stop.d8", 32'(bus.duty_out), 32'h008);
        step(4);
        check_outs("stop.d0", 3'd1, 1'b1, 10'h000);
        step(1);
        check_outs("stop.idle", 3'd0, 1'b0, 10'h000);
        send_cmd(10'h014);
        step(10);
        bus.connected = 1'b0;
        step(1);
        bus.connected = 1'b1;
        check("stop.retry0", 32'(bus.state), 32'd3);
        check("stop.nolock", 32'(bus.fault_latched), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
